// File: rtl/csr_pkg.sv
// csr_pkg: CSR addresses, access op encodings and bit indices
// shared by the machine-mode CSR unit and its counters.
package csr_pkg;

   localparam logic [11:0] CSR_MSTATUS  = 12'h300;
   localparam logic [11:0] CSR_MIE      = 12'h304;
   localparam logic [11:0] CSR_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH = 12'h340;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;
   localparam logic [11:0] CSR_MTVAL    = 12'h343;
   localparam logic [11:0] CSR_MIP      = 12'h344;
   localparam logic [11:0] CSR_MHARTID  = 12'hF14;
   localparam logic [11:0] CSR_CYCLE    = 12'hC00;
   localparam logic [11:0] CSR_TIME     = 12'hC01;
   localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
   localparam logic [11:0] CSR_TIMEH    = 12'hC81;

   localparam logic [1:0] OP_NONE = 2'b00;
   localparam logic [1:0] OP_RW   = 2'b01;
   localparam logic [1:0] OP_RS   = 2'b10;
   localparam logic [1:0] OP_RC   = 2'b11;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;
   localparam int MIP_MTIP     = 7;
   localparam int MIP_MEIP     = 11;

   // mcause interrupt flag sits in the top bit of the CSR
   function automatic int cause_msb(input int xlen);
      return xlen - 1;
   endfunction

endpackage

// File: rtl/csr_counter.sv
// csr_counter: 64-bit free-running counter advanced once
// every DIV enabled clocks through a small prescaler.
module csr_counter #(
   parameter int DIV = 1
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_en,
   output logic [63:0] o_count
);

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [PW-1:0] pre_d, pre_q;
   logic [63:0]   cnt_d, cnt_q;
   logic          tick;

   // prescaler wraps at DIV-1 and emits one tick per wrap
   always_comb begin
      pre_d = pre_q;
      cnt_d = cnt_q;
      tick  = 1'b0;
      if (i_en) begin
         if (pre_q == PW'(DIV - 1)) begin
            pre_d = '0;
            tick  = 1'b1;
         end else begin
            pre_d = pre_q + 1'b1;
         end
      end
      if (tick) cnt_d = cnt_q + 64'd1;
   end

   // counter and prescaler state
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         pre_q <= '0;
         cnt_q <= '0;
      end else begin
         pre_q <= pre_d;
         cnt_q <= cnt_d;
      end
   end

   assign o_count = cnt_q;

endmodule

// File: rtl/csr_unit.sv
// csr_unit: M-mode CSR file, trap entry / MRET sequencing.
// Counters (cycle/time) exist only with CSR_COUNTERS_EN defined.
module csr_unit
   import csr_pkg::*;
#(
   parameter int          XLEN      = 32,
   parameter int          HARTID    = 0,
   parameter logic [31:0] RESET_VEC = 32'h0000_0000,
   parameter int          TIME_DIV  = 1
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_req,
   input  logic [1:0]      i_op,
   input  logic [11:0]     i_addr,
   input  logic [XLEN-1:0] i_wdata,
   output logic [XLEN-1:0] o_rdata,
   output logic            o_illegal,
   input  logic            i_trap,
   input  logic [XLEN-1:0] i_cause,
   input  logic [XLEN-1:0] i_epc,
   input  logic [XLEN-1:0] i_tval,
   input  logic            i_mret,
   input  logic            i_tmr_irq,
   input  logic            i_ext_irq,
   output logic            o_irq,
   output logic            o_redirect,
   output logic [XLEN-1:0] o_target
);

   localparam int CMSB = cause_msb(XLEN);

   logic            mie_bit_d, mie_bit_q;
   logic            mpie_d, mpie_q;
   logic [XLEN-1:0] mie_d, mie_q;
   logic [XLEN-1:0] mtvec_d, mtvec_q;
   logic [XLEN-1:0] mscratch_d, mscratch_q;
   logic [XLEN-1:0] mepc_d, mepc_q;
   logic [XLEN-1:0] mcause_d, mcause_q;
   logic [XLEN-1:0] mtval_d, mtval_q;
   logic            redirect_d, redirect_q;
   logic [XLEN-1:0] target_d, target_q;

   logic [XLEN-1:0] mip_val, rdata, wval, tbase, trap_tgt;
   logic            known, ro, is_write, illegal, we;

`ifdef CSR_COUNTERS_EN
   logic [63:0] cycle_cnt, time_cnt;

   csr_counter #(.DIV(1)) u_cycle (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (1'b1),
      .o_count (cycle_cnt)
   );

   csr_counter #(.DIV(TIME_DIV)) u_time (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (1'b1),
      .o_count (time_cnt)
   );
`endif

   // pending lines are sampled live, never stored
   always_comb begin
      mip_val           = '0;
      mip_val[MIP_MTIP] = i_tmr_irq;
      mip_val[MIP_MEIP] = i_ext_irq;
   end

   // address decode: old value, existence, read-only flag
   always_comb begin
      rdata = '0;
      known = 1'b1;
      ro    = 1'b0;
      unique case (i_addr)
         CSR_MSTATUS: begin
            rdata[MSTATUS_MIE]  = mie_bit_q;
            rdata[MSTATUS_MPIE] = mpie_q;
         end
         CSR_MIE:      rdata = mie_q;
         CSR_MIP:      rdata = mip_val;
         CSR_MTVEC:    rdata = mtvec_q;
         CSR_MSCRATCH: rdata = mscratch_q;
         CSR_MEPC:     rdata = mepc_q;
         CSR_MCAUSE:   rdata = mcause_q;
         CSR_MTVAL:    rdata = mtval_q;
         CSR_MHARTID: begin
            rdata = XLEN'(HARTID);
            ro    = 1'b1;
         end
`ifdef CSR_COUNTERS_EN
         CSR_CYCLE: begin
            rdata = XLEN'(cycle_cnt);
            ro    = 1'b1;
         end
         CSR_TIME: begin
            rdata = XLEN'(time_cnt);
            ro    = 1'b1;
         end
         CSR_CYCLEH: begin
            rdata = XLEN'(cycle_cnt >> 32);
            ro    = 1'b1;
            known = (XLEN == 32);
         end
         CSR_TIMEH: begin
            rdata = XLEN'(time_cnt >> 32);
            ro    = 1'b1;
            known = (XLEN == 32);
         end
`endif
         default: known = 1'b0;
      endcase
   end

   // RS/RC with zero operand is a pure read
   always_comb begin
      is_write = (i_op == OP_RW) || ((i_op != OP_NONE) && (|i_wdata));
      illegal  = !known || (i_op == OP_NONE) || (ro && is_write);
      we       = i_req && !illegal && is_write && !i_trap && !i_mret;
      wval     = rdata;
      unique case (i_op)
         OP_RW:   wval = i_wdata;
         OP_RS:   wval = rdata | i_wdata;
         OP_RC:   wval = rdata & ~i_wdata;
         default: wval = rdata;
      endcase
   end

   assign o_illegal = i_req && illegal;
   assign o_rdata   = illegal ? '0 : rdata;
   assign o_irq     = mie_bit_q && (|(mie_q & mip_val));

   // trap target, vectored for interrupts when mtvec mode is 01
   always_comb begin
      tbase    = {mtvec_q[XLEN-1:2], 2'b00};
      trap_tgt = tbase;
      if (mtvec_q[1:0] == 2'b01 && i_cause[CMSB])
         trap_tgt = tbase + {i_cause[XLEN-3:0], 2'b00};
   end

   // next state: trap beats MRET beats software write
   always_comb begin
      mie_bit_d  = mie_bit_q;
      mpie_d     = mpie_q;
      mie_d      = mie_q;
      mtvec_d    = mtvec_q;
      mscratch_d = mscratch_q;
      mepc_d     = mepc_q;
      mcause_d   = mcause_q;
      mtval_d    = mtval_q;
      redirect_d = i_trap || i_mret;
      target_d   = target_q;
      if (i_trap) begin
         mepc_d    = {i_epc[XLEN-1:2], 2'b00};
         mcause_d  = i_cause;
         mtval_d   = i_tval;
         mpie_d    = mie_bit_q;
         mie_bit_d = 1'b0;
         target_d  = trap_tgt;
      end else if (i_mret) begin
         mie_bit_d = mpie_q;
         mpie_d    = 1'b1;
         target_d  = mepc_q;
      end else if (we) begin
         unique case (i_addr)
            CSR_MSTATUS: begin
               mie_bit_d = wval[MSTATUS_MIE];
               mpie_d    = wval[MSTATUS_MPIE];
            end
            CSR_MIE:      mie_d      = wval;
            CSR_MTVEC:    mtvec_d    = wval;
            CSR_MSCRATCH: mscratch_d = wval;
            CSR_MEPC:     mepc_d     = {wval[XLEN-1:2], 2'b00};
            CSR_MCAUSE:   mcause_d   = wval;
            CSR_MTVAL:    mtval_d    = wval;
            default:      ;
         endcase
      end
   end

   // CSR state and registered redirect
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         mie_bit_q  <= 1'b0;
         mpie_q     <= 1'b0;
         mie_q      <= '0;
         mtvec_q    <= XLEN'(RESET_VEC);
         mscratch_q <= '0;
         mepc_q     <= '0;
         mcause_q   <= '0;
         mtval_q    <= '0;
         redirect_q <= 1'b0;
         target_q   <= '0;
      end else begin
         mie_bit_q  <= mie_bit_d;
         mpie_q     <= mpie_d;
         mie_q      <= mie_d;
         mtvec_q    <= mtvec_d;
         mscratch_q <= mscratch_d;
         mepc_q     <= mepc_d;
         mcause_q   <= mcause_d;
         mtval_q    <= mtval_d;
         redirect_q <= redirect_d;
         target_q   <= target_d;
      end
   end

   assign o_redirect = redirect_q;
   assign o_target   = target_q;

endmodule
